// File: rtl/game_turn_controller_pkg.sv
// game_turn_controller_pkg: shared state/winner encodings and game defaults
package game_turn_controller_pkg;
    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam int DEF_WIN_SCORE = 10;
endpackage

// File: rtl/game_turn_controller_if.sv
// game_turn_controller_if: board/datapath events in, game status out
interface game_turn_controller_if #(
    parameter int SCORE_W = 4,
    parameter int TIMER_W = 8
) ();
    logic               start;
    logic               tick;
    logic               goal;
    logic               hit;
    logic [1:0]         state;
    logic               active_player;
    logic               move_en;
    logic               player_home;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [TIMER_W-1:0] turn_timer;
    logic [1:0]         winner;

    modport master (
        output start, tick, goal, hit,
        input  state, active_player, move_en, player_home,
        input  p1_score, p2_score, turn_timer, winner
    );

    modport slave (
        input  start, tick, goal, hit,
        output state, active_player, move_en, player_home,
        output p1_score, p2_score, turn_timer, winner
    );
endinterface

// File: rtl/game_turn_controller_sync_edge.sv
// game_turn_controller_sync_edge: 2-flop synchronizer with rise/low detect, rise armed only after a low is seen
module game_turn_controller_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic low
);
    logic s1, s2, s3, fill0, fill1, armed;

    // fill0/fill1 mark when s2 holds a real sample, so the reset value of s2 cannot arm the edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {s1, s2, s3, fill0, fill1, armed} <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            fill0 <= 1'b1;
            fill1 <= fill0;
            armed <= armed | (fill1 & ~s2);
        end
    end

    assign rise = armed & s2 & ~s3;
    assign low  = ~s2;
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: two-player game sequencer (turns, scores, timeout, respawn)
module game_turn_controller
    import game_turn_controller_pkg::*;
#(
    parameter int WIN_SCORE  = DEF_WIN_SCORE,
    parameter int SCORE_W    = 4,
    parameter int TURN_TICKS = 64,
    parameter int TIMER_W    = 8
) (
    input logic                   clk,
    input logic                   reset,
    game_turn_controller_if.slave bus
);
    localparam logic [TIMER_W-1:0] T_MAX = TIMER_W'(TURN_TICKS - 1);
    localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d, other;
    winner_t            winner_q, winner_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, cur_inc;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               home_q, home_d, start_rise, start_low, p2_turn, timeout;

    game_turn_controller_sync_edge u_start (
        .clk  (clk),
        .reset(reset),
        .din  (bus.start),
        .rise (start_rise),
        .low  (start_low)
    );

    assign p2_turn = (state_q == QGAME_2);
    assign other   = p2_turn ? QGAME_1 : QGAME_2;
    assign cur_inc = (p2_turn ? p2_q : p1_q) + SCORE_W'(1);
    assign timeout = bus.tick && (timer_q == T_MAX);

    assign bus.state         = state_q;
    assign bus.active_player = p2_turn;
    assign bus.move_en       = (state_q == QGAME_1) || (state_q == QGAME_2);
    assign bus.player_home   = home_q;
    assign bus.p1_score      = p1_q;
    assign bus.p2_score      = p2_q;
    assign bus.turn_timer    = timer_q;
    assign bus.winner        = winner_q;

    // State and game registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= QI;
            winner_q <= WIN_NONE;
            p1_q     <= '0;
            p2_q     <= '0;
            timer_q  <= '0;
            home_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            timer_q  <= timer_d;
            home_q   <= home_d;
        end
    end

    // Next state: one event per cycle, priority hit > goal > timeout
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        timer_d  = timer_q;
        home_d   = 1'b0;
        case (state_q)
            QI: begin
                if (start_rise) begin
                    state_d = QGAME_1;
                    home_d  = 1'b1;
                    timer_d = '0;
                end
            end
            QGAME_1, QGAME_2: begin
                if (bus.hit || (!bus.goal && timeout)) begin
                    state_d = other;
                    home_d  = 1'b1;
                    timer_d = '0;
                end else if (bus.goal) begin
                    if (p2_turn) p2_d = cur_inc;
                    else p1_d = cur_inc;
                    if (cur_inc == S_WIN) begin
                        state_d  = QDONE;
                        winner_d = p2_turn ? WIN_P2 : WIN_P1;
                    end else begin
                        state_d = other;
                        home_d  = 1'b1;
                        timer_d = '0;
                    end
                end else if (bus.tick) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                if (start_low) begin
                    state_d  = QI;
                    winner_d = WIN_NONE;
                    p1_d     = '0;
                    p2_d     = '0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: scoreboard bench for game_turn_controller (TURN_TICKS=4)
module tb_game_turn_controller;
    typedef struct {
        int st, p1, p2, tm, wn, hm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   stepn = 0;
    exp_t exp_q[$];

    game_turn_controller_if #(.SCORE_W(4), .TIMER_W(8)) bus ();

    game_turn_controller #(
        .WIN_SCORE (10),
        .SCORE_W   (4),
        .TURN_TICKS(4),
        .TIMER_W   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d exp=%0d", tag, stepn, got, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(bus.state), e.st);
            chk("p1_score", int'(bus.p1_score), e.p1);
            chk("p2_score", int'(bus.p2_score), e.p2);
            chk("turn_timer", int'(bus.turn_timer), e.tm);
            chk("winner", int'(bus.winner), e.wn);
            chk("player_home", int'(bus.player_home), e.hm);
            chk("move_en", int'(bus.move_en), (e.st == 1 || e.st == 2) ? 1 : 0);
            chk("active_player", int'(bus.active_player), (e.st == 2) ? 1 : 0);
            stepn++;
        end
    endtask

    task automatic step(input bit t, input bit g, input bit h,
                        input int st, input int p1, input int p2,
                        input int tm, input int wn, input int hm);
        exp_q.push_back('{st, p1, p2, tm, wn, hm});
        bus.tick = t;
        bus.goal = g;
        bus.hit  = h;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.goal = 1'b0;
        bus.hit  = 1'b0;
        drain();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        bus.goal  = 1'b0;
        bus.hit   = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{0, 0, 0, 0, 0, 0});
        drain();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // first game start: rise seen two edges after pin, acted on the third
        bus.start = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // timeout after four ticks with no event
        step(1, 0, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0, 2, 0, 0);
        step(1, 0, 0, 1, 0, 0, 3, 0, 0);
        step(1, 0, 0, 2, 0, 0, 0, 0, 1);

        // hit beats goal in the same cycle
        step(1, 0, 0, 2, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0, 1);

        // P1 reaches 3, game left in QGAME_2 with a running timer
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, 2, i, 0, 0, 0, 1);
            if (i < 3) step(0, 0, 1, 1, i, 0, 0, 0, 1);
        end
        step(1, 0, 0, 2, 3, 0, 1, 0, 0);

        // asynchronous reset mid-game, start held high
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back('{0, 0, 0, 0, 0, 0});
        drain();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lower start; events in QI are ignored
        bus.start = 1'b0;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // P1 climbs to 9, P2 scores once
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 0, 1, i - 1, (i > 2) ? 1 : 0, 1, 0, 0);
            step(0, 1, 0, 2, i, (i > 2) ? 1 : 0, 0, 0, 1);
            if (i == 2) step(0, 1, 0, 1, i, 1, 0, 0, 1);
            else step(0, 0, 1, 1, i, (i > 2) ? 1 : 0, 0, 0, 1);
        end

        // winning goal: no respawn, winner P1
        step(0, 1, 0, 3, 10, 1, 0, 1, 0);
        step(0, 0, 0, 3, 10, 1, 0, 1, 0);

        // events in QDONE are ignored, start still high keeps QDONE
        step(1, 1, 0, 3, 10, 1, 0, 1, 0);
        step(0, 0, 1, 3, 10, 1, 0, 1, 0);

        // start low returns to QI and clears scores/winner
        bus.start = 1'b0;
        step(0, 0, 0, 3, 10, 1, 0, 1, 0);
        step(0, 0, 0, 3, 10, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
